// File: rtl/doodle_pkg.sv
// ---------------------------------------------------------------------------
// doodle_pkg
//   Shared types and constants for the GameBox input conditioner.
//   - ch_state_t          : per-channel press/auto-repeat FSM state
//   - CONFLICT_CANCEL     : left+right held together cancels both
//   - CONFLICT_LAST_WINS  : most recently pressed of left/right wins
//   - CH_LEFT / CH_RIGHT  : channel indices of the two conflicting buttons
// ---------------------------------------------------------------------------
package doodle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_REPEAT  = 2'd2
    } ch_state_t;

    localparam int CONFLICT_CANCEL    = 0;
    localparam int CONFLICT_LAST_WINS = 1;

    localparam int CH_LEFT  = 0;
    localparam int CH_RIGHT = 1;

endpackage

// File: rtl/input_channel.sv
// ---------------------------------------------------------------------------
// input_channel
//   One button channel: 2-flop synchroniser, debounce counter and the
//   press/auto-repeat FSM with its repeat counter.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   i_btn_raw  in   raw asynchronous button level, 1 = pressed
//   o_held     out  debounced level (registered)
//   o_held_nxt out  value o_held takes at the next edge (combinational)
//   o_event    out  press / repeat event, valid for the edge it is high on
//                   (combinational, the top registers its effect)
//   o_state    out  FSM state, for observation
// ---------------------------------------------------------------------------
module input_channel
    import doodle_pkg::*;
#(
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4,
    parameter int CNT_W         = 8
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      i_btn_raw,
    output logic      o_held,
    output logic      o_held_nxt,
    output logic      o_event,
    output ch_state_t o_state
);

    localparam logic [CNT_W-1:0] L_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_DB     = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] L_DELAY  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] L_PERIOD = CNT_W'(REPEAT_PERIOD);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_held;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] r_rep_cnt;
    logic [CNT_W-1:0] w_rep_cnt_nxt;
    ch_state_t        r_state;
    ch_state_t        w_state_nxt;

    logic w_toggle;
    logic w_rise;
    logic w_fall;
    logic w_delay_hit;
    logic w_period_hit;

    // The debounced level flips on the edge where the DB_CYCLES-th
    // consecutive disagreeing synchronised sample is seen.
    assign w_toggle = (r_sync2 != r_held) && ((r_db_cnt + L_ONE) == L_DB);
    assign w_rise   = w_toggle && !r_held;
    assign w_fall   = w_toggle && r_held;

    assign w_delay_hit  = (REPEAT_DELAY != 0) && ((r_rep_cnt + L_ONE) == L_DELAY);
    assign w_period_hit = ((r_rep_cnt + L_ONE) == L_PERIOD);

    assign o_held     = r_held;
    assign o_held_nxt = r_held ^ w_toggle;
    assign o_state    = r_state;

    // Synchroniser and debounce
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_held   <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_held) begin
                r_db_cnt <= '0;
            end else if (w_toggle) begin
                r_db_cnt <= '0;
                r_held   <= ~r_held;
            end else begin
                r_db_cnt <= r_db_cnt + L_ONE;
            end
        end
    end

    // FSM: state register (the repeat counter travels with the state)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_rep_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rep_cnt <= w_rep_cnt_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt   = r_state;
        w_rep_cnt_nxt = r_rep_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt   = ST_PRESSED;
                    w_rep_cnt_nxt = '0;
                end
            end
            ST_PRESSED: begin
                if (w_fall) begin
                    w_state_nxt   = ST_IDLE;
                    w_rep_cnt_nxt = '0;
                end else if (REPEAT_DELAY != 0) begin
                    if (w_delay_hit) begin
                        w_state_nxt   = ST_REPEAT;
                        w_rep_cnt_nxt = '0;
                    end else begin
                        w_rep_cnt_nxt = r_rep_cnt + L_ONE;
                    end
                end
            end
            ST_REPEAT: begin
                if (w_fall) begin
                    w_state_nxt   = ST_IDLE;
                    w_rep_cnt_nxt = '0;
                end else if (w_period_hit) begin
                    w_rep_cnt_nxt = '0;
                end else begin
                    w_rep_cnt_nxt = r_rep_cnt + L_ONE;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_rep_cnt_nxt = '0;
            end
        endcase
    end

    // FSM: outputs. A release never produces an event, even on a repeat edge.
    always_comb begin
        o_event = 1'b0;
        case (r_state)
            ST_IDLE:    o_event = w_rise;
            ST_PRESSED: o_event = !w_fall && w_delay_hit;
            ST_REPEAT:  o_event = !w_fall && w_period_hit;
            default:    o_event = 1'b0;
        endcase
    end

endmodule

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//   Front end between raw player buttons and GameBox. Each channel is
//   synchronised, debounced and turned into press/auto-repeat events; the
//   top applies left/right conflict masking and keeps sticky pending and
//   overrun flags per channel.
//
//   Event/ack handshake: an event sets press_pend; press_pend stays high
//   until the consumer pulses ack for one cycle. An ack on the same edge as
//   a new event keeps press_pend high (the new event is not lost) and clears
//   overrun. An event that finds press_pend high and unacked sets overrun.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   btn_raw      in   [N_CH] raw button levels, 1 = pressed
//   ack          in   [N_CH] per-channel clear of press_pend / overrun
//   held         out  [N_CH] debounced levels, before conflict masking
//   move         out  [N_CH] held after conflict masking
//   press_pend   out  [N_CH] sticky event flags
//   overrun      out  [N_CH] sticky lost-event flags
//   o_dbg_state  out  [2*N_CH] per-channel FSM state, channel g at [2g+:2]
// ---------------------------------------------------------------------------
module input_conditioner
    import doodle_pkg::*;
#(
    parameter int N_CH          = 2,
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4,
    parameter int CNT_W         = 8,
    parameter int CONFLICT_MODE = CONFLICT_CANCEL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   btn_raw,
    input  logic [N_CH-1:0]   ack,
    output logic [N_CH-1:0]   held,
    output logic [N_CH-1:0]   move,
    output logic [N_CH-1:0]   press_pend,
    output logic [N_CH-1:0]   overrun,
    output logic [2*N_CH-1:0] o_dbg_state
);

    logic [N_CH-1:0] w_held_nxt;
    logic [N_CH-1:0] w_event_raw;
    logic [N_CH-1:0] w_event;
    logic [N_CH-1:0] w_move_nxt;
    logic [N_CH-1:0] r_move;
    logic [N_CH-1:0] r_pend;
    logic [N_CH-1:0] r_ovr;
    ch_state_t       w_state [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        input_channel #(
            .DB_CYCLES     (DB_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .CNT_W         (CNT_W)
        ) u_channel (
            .clk        (clk),
            .reset      (reset),
            .i_btn_raw  (btn_raw[g]),
            .o_held     (held[g]),
            .o_held_nxt (w_held_nxt[g]),
            .o_event    (w_event_raw[g]),
            .o_state    (w_state[g])
        );
        assign o_dbg_state[2*g +: 2] = w_state[g];
    end

    // Masking is evaluated on the next-edge held values so that move and
    // the event gating line up with the held edge they belong to.
    if (N_CH >= 2) begin : g_conflict
        logic r_winner;      // 0 = left (CH_LEFT), 1 = right (CH_RIGHT)
        logic w_winner_nxt;
        logic w_rise_l;
        logic w_rise_r;
        logic w_both;

        assign w_rise_l = w_held_nxt[CH_LEFT]  && !held[CH_LEFT];
        assign w_rise_r = w_held_nxt[CH_RIGHT] && !held[CH_RIGHT];
        assign w_both   = w_held_nxt[CH_LEFT]  && w_held_nxt[CH_RIGHT];

        // Newest rise wins (left on a tie); if the winner lets go while the
        // other is still held, the other takes over without a new event.
        always_comb begin
            w_winner_nxt = r_winner;
            if (w_rise_l) begin
                w_winner_nxt = 1'b0;
            end else if (w_rise_r) begin
                w_winner_nxt = 1'b1;
            end else if (!r_winner && !w_held_nxt[CH_LEFT] && w_held_nxt[CH_RIGHT]) begin
                w_winner_nxt = 1'b1;
            end else if (r_winner && !w_held_nxt[CH_RIGHT] && w_held_nxt[CH_LEFT]) begin
                w_winner_nxt = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_winner <= 1'b0;
            end else begin
                r_winner <= w_winner_nxt;
            end
        end

        always_comb begin
            w_move_nxt = w_held_nxt;
            w_event    = w_event_raw;
            if (w_both) begin
                if (CONFLICT_MODE == CONFLICT_LAST_WINS) begin
                    w_move_nxt[CH_LEFT]  = !w_winner_nxt;
                    w_move_nxt[CH_RIGHT] = w_winner_nxt;
                    if (w_winner_nxt) begin
                        w_event[CH_LEFT] = 1'b0;
                    end else begin
                        w_event[CH_RIGHT] = 1'b0;
                    end
                end else begin
                    w_move_nxt[CH_LEFT]  = 1'b0;
                    w_move_nxt[CH_RIGHT] = 1'b0;
                    w_event[CH_LEFT]     = 1'b0;
                    w_event[CH_RIGHT]    = 1'b0;
                end
            end
        end
    end else begin : g_no_conflict
        assign w_move_nxt = w_held_nxt;
        assign w_event    = w_event_raw;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_move <= '0;
            r_pend <= '0;
            r_ovr  <= '0;
        end else begin
            r_move <= w_move_nxt;
            for (int i = 0; i < N_CH; i++) begin
                if (w_event[i]) begin
                    r_pend[i] <= 1'b1;
                    r_ovr[i]  <= ack[i] ? 1'b0 : (r_ovr[i] | r_pend[i]);
                end else if (ack[i]) begin
                    r_pend[i] <= 1'b0;
                    r_ovr[i]  <= 1'b0;
                end
            end
        end
    end

    assign move       = r_move;
    assign press_pend = r_pend;
    assign overrun    = r_ovr;

endmodule

// File: tb/tb_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_input_conditioner
//   Two conditioners (cancel mode and last-wins mode) share the same button
//   and ack stimulus. A behavioural model derived from the button rules is
//   stepped every clock and compared against both; directed steps add
//   fixed expectations at the interesting points.
// ---------------------------------------------------------------------------
module tb_input_conditioner;
    import doodle_pkg::*;

    localparam int DB = 4;
    localparam int RD = 16;
    localparam int RP = 4;

    // clock / reset
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] btn;
    logic [1:0] ack;
    logic [1:0] held0, move0, pend0, ovr0;
    logic [1:0] held1, move1, pend1, ovr1;
    logic [3:0] dbg0, dbg1;

    input_conditioner #(
        .N_CH(2), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
        .CNT_W(8), .CONFLICT_MODE(CONFLICT_CANCEL)
    ) u_dut0 (
        .clk(clk), .reset(reset), .btn_raw(btn), .ack(ack),
        .held(held0), .move(move0), .press_pend(pend0), .overrun(ovr0),
        .o_dbg_state(dbg0)
    );

    input_conditioner #(
        .N_CH(2), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
        .CNT_W(8), .CONFLICT_MODE(CONFLICT_LAST_WINS)
    ) u_dut1 (
        .clk(clk), .reset(reset), .btn_raw(btn), .ack(ack),
        .held(held1), .move(move1), .press_pend(pend1), .overrun(ovr1),
        .o_dbg_state(dbg1)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    int         n;                 // edges since reset release
    bit         raw_h [2][0:8191]; // raw level sampled at each edge
    bit         s_h   [2][0:8191]; // synchronised level seen at each edge
    logic [1:0] held_m;
    int         t_m   [2];         // edges since the debounced press
    logic [1:0] pend_m [2];
    logic [1:0] ovr_m  [2];
    logic [1:0] mv_m   [2];
    int         win_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic model_reset();
        n      = 0;
        held_m = 2'b00;
        win_m  = 0;
        for (int m = 0; m < 2; m++) begin
            t_m[m]    = 0;
            pend_m[m] = 2'b00;
            ovr_m[m]  = 2'b00;
            mv_m[m]   = 2'b00;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_held0"}, held0, 0);
        chk({tag, "_move0"}, move0, 0);
        chk({tag, "_pend0"}, pend0, 0);
        chk({tag, "_ovr0"},  ovr0,  0);
        chk({tag, "_held1"}, held1, 0);
        chk({tag, "_move1"}, move1, 0);
        chk({tag, "_pend1"}, pend1, 0);
        chk({tag, "_ovr1"},  ovr1,  0);
    endtask

    // One clock edge with the current btn/ack, then model update and compare.
    task automatic step();
        logic [1:0] hn, rise, ev, msk;
        logic [1:0] evm [2];
        bit         tg;
        @(posedge clk);
        #1;
        n++;
        for (int c = 0; c < 2; c++) begin
            raw_h[c][n] = btn[c];
            s_h[c][n]   = (n >= 3) ? raw_h[c][n-2] : 1'b0;
            // level changes once DB consecutive samples disagree with it
            tg = (n >= DB);
            for (int k = 0; k < DB; k++)
                if (tg && (s_h[c][n-k] == held_m[c])) tg = 1'b0;
            hn[c]   = held_m[c] ^ tg;
            rise[c] = tg & ~held_m[c];
            if (rise[c]) begin
                t_m[c] = 0;
                ev[c]  = 1'b1;
            end else if (hn[c]) begin
                t_m[c]++;
                ev[c] = (RD > 0) && (t_m[c] >= RD) && (((t_m[c] - RD) % RP) == 0);
            end else begin
                ev[c] = 1'b0;
            end
        end
        if (rise[0])                      win_m = 0;
        else if (rise[1])                 win_m = 1;
        else if (!hn[win_m] && hn[1-win_m]) win_m = 1 - win_m;

        mv_m[0] = (hn == 2'b11) ? 2'b00 : hn;
        evm[0]  = (hn == 2'b11) ? 2'b00 : ev;
        msk     = (hn == 2'b11) ? ((win_m == 1) ? 2'b10 : 2'b01) : 2'b11;
        mv_m[1] = hn & msk;
        evm[1]  = ev & msk;
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 2; c++) begin
                if (evm[m][c]) begin
                    ovr_m[m][c]  = ack[c] ? 1'b0 : (ovr_m[m][c] | pend_m[m][c]);
                    pend_m[m][c] = 1'b1;
                end else if (ack[c]) begin
                    pend_m[m][c] = 1'b0;
                    ovr_m[m][c]  = 1'b0;
                end
            end
        end
        held_m = hn;

        chk("m_held0", held0, held_m);
        chk("m_move0", move0, mv_m[0]);
        chk("m_pend0", pend0, pend_m[0]);
        chk("m_ovr0",  ovr0,  ovr_m[0]);
        chk("m_held1", held1, held_m);
        chk("m_move1", move1, mv_m[1]);
        chk("m_pend1", pend1, pend_m[1]);
        chk("m_ovr1",  ovr1,  ovr_m[1]);
    endtask

    task automatic idle(input int cycles);
        btn = 2'b00;
        ack = 2'b11;
        for (int i = 0; i < cycles; i++) step();
        ack = 2'b00;
    endtask

    int ev_list [7] = '{0, 16, 20, 24, 28, 32, 36};

    initial begin
        logic exp_p;
        btn   = 2'b00;
        ack   = 2'b00;
        reset = 1'b0;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("rst");
        chk("rst_dbg0", dbg0, {ST_IDLE, ST_IDLE});
        chk("rst_dbg1", dbg1, {ST_IDLE, ST_IDLE});
        #2 reset = 1'b1;
        model_reset();

        // debounce latency, no second event before +16, overrun, same-edge ack
        btn = 2'b01;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i < 6) chk("lat_held_lo", held0, 2'b00);
        end
        chk("lat_held", held0, 2'b01);
        chk("lat_pend", pend0, 2'b01);
        chk("lat_move0", move0, 2'b01);
        chk("lat_move1", move1, 2'b01);
        for (int j = 1; j <= 15; j++) begin
            step();
            chk("nodup_ovr", ovr0, 2'b00);
            chk("nodup_pend", pend0, 2'b01);
        end
        step();
        chk("ovr_set", ovr0, 2'b01);
        repeat (3) step();
        ack = 2'b01;
        step();
        chk("same_edge_pend", pend0, 2'b01);
        chk("same_edge_ovr", ovr0, 2'b00);
        step();
        chk("ack_clear", pend0, 2'b00);
        ack = 2'b00;
        btn = 2'b00;
        repeat (10) step();
        idle(2);

        // glitch rejection on channel 1
        btn = 2'b10;
        for (int i = 0; i < 11; i++) begin
            if (i == 3) btn = 2'b00;
            step();
            chk("gl_held", held0[1], 1'b0);
            chk("gl_pend", pend0[1], 1'b0);
            chk("gl_ovr",  ovr0[1],  1'b0);
        end

        // auto-repeat with ack one cycle after each event
        btn = 2'b01;
        for (int i = 1; i <= 45; i++) begin
            ack = {1'b0, pend_m[0][0]};
            step();
            if (i >= 6) begin
                exp_p = 1'b0;
                foreach (ev_list[k]) if (ev_list[k] == i - 6) exp_p = 1'b1;
                chk("rep_pend", pend0[0], exp_p);
                chk("rep_ovr", ovr0[0], 1'b0);
            end
        end
        idle(10);

        // conflict: right pressed two cycles after left
        btn = 2'b01;
        ack = 2'b11;
        for (int e = 1; e <= 30; e++) begin
            if (e == 3) btn = 2'b11;
            step();
            if (e == 6) begin
                chk("c_l_move0", move0, 2'b01);
                chk("c_l_move1", move1, 2'b01);
                chk("c_l_pend1", pend1, 2'b01);
            end
            if (e == 8) chk("c_r_pend1", pend1, 2'b10);
            if (e >= 8) begin
                chk("c0_move", move0, 2'b00);
                chk("c0_pend", pend0, 2'b00);
                chk("c1_move", move1, 2'b10);
                chk("c1_pend_l", pend1[0], 1'b0);
            end
        end
        btn = 2'b01;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e < 6) chk("h_move1_pre", move1, 2'b10);
            if (e == 6) begin
                chk("h_move1", move1, 2'b01);
                chk("h_move0", move0, 2'b01);
                chk("h_noev1", pend1[0], 1'b0);
            end
            if (e == 8) begin
                chk("h_rep1", pend1[0], 1'b1);
                chk("h_rep0", pend0[0], 1'b1);
            end
        end
        idle(12);

        // simultaneous rise: left wins
        btn = 2'b11;
        ack = 2'b11;
        repeat (6) step();
        chk("sim_move0", move0, 2'b00);
        chk("sim_move1", move1, 2'b01);
        chk("sim_pend0", pend0, 2'b00);
        chk("sim_pend1", pend1, 2'b01);
        idle(12);

        // randomized buttons and acks against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) btn[0] = ~btn[0];
            if ($urandom_range(0, 29) == 0) btn[1] = ~btn[1];
            ack[0] = ($urandom_range(0, 3) == 0);
            ack[1] = ($urandom_range(0, 3) == 0);
            step();
        end
        idle(12);

        // asynchronous reset while repeating, button kept pressed
        btn = 2'b01;
        repeat (30) step();
        #3 reset = 1'b0;
        #1;
        chk_all_zero("arst");
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        model_reset();
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i < 6) chk("arst_held_lo", held0, 2'b00);
        end
        chk("arst_held", held0, 2'b01);
        chk("arst_pend", pend0, 2'b01);
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
